// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions: receiver/transmitter FSM states and frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a one-entry valid/ready output buffer.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 io_clk,
    input  logic                 io_reset_n,
    input  logic                 io_rx,
    output logic                 io_data_valid,
    input  logic                 io_data_ready,
    output logic [DATA_BITS-1:0] io_data_payload,
    output logic                 io_frame_err,
    output logic                 io_overrun,
    output logic                 io_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    uart_state_t          state, state_next;
    logic [CNT_W-1:0]     baud_cnt, baud_next;
    logic [BIT_W-1:0]     bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 rx_sync;
    logic                 deliver;
    logic                 frame_err_set;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (IDLE_LEVEL)
    ) u_sync (
        .clk   (io_clk),
        .rst_n (io_reset_n),
        .d     (io_rx),
        .q     (rx_sync)
    );

    always_ff @(posedge io_clk or negedge io_reset_n) begin
        if (!io_reset_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
        end
    end

    always_comb begin
        state_next    = state;
        baud_next     = baud_cnt;
        bit_next      = bit_cnt;
        shift_next    = shift;
        deliver       = 1'b0;
        frame_err_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_sync != IDLE_LEVEL) begin
                    state_next = ST_START;
                    bit_next   = '0;
                    baud_next  = HALF_LOAD;
                end
            end
            ST_START: begin
                // A start bit that is gone by mid-bit is treated as a glitch.
                if (baud_cnt == '0) begin
                    if (rx_sync != IDLE_LEVEL) begin
                        state_next = ST_DATA;
                        baud_next  = FULL_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    baud_next = baud_cnt - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_cnt == '0) begin
                    shift_next = {rx_sync, shift[DATA_BITS-1:1]};
                    baud_next  = FULL_LOAD;
                    bit_next   = bit_cnt + BIT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state_next = ST_STOP;
                    end
                end else begin
                    baud_next = baud_cnt - CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_cnt == '0) begin
                    if (rx_sync == IDLE_LEVEL) begin
                        deliver    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        frame_err_set = 1'b1;
                        state_next    = ST_WAIT_IDLE;
                    end
                end else begin
                    baud_next = baud_cnt - CNT_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_sync == IDLE_LEVEL) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A byte completing while the buffer is drained that same cycle still loads.
    always_ff @(posedge io_clk or negedge io_reset_n) begin
        if (!io_reset_n) begin
            io_data_valid   <= 1'b0;
            io_data_payload <= '0;
            io_frame_err    <= 1'b0;
            io_overrun      <= 1'b0;
        end else begin
            io_frame_err <= frame_err_set;
            io_overrun   <= 1'b0;
            if (deliver) begin
                if (!io_data_valid || io_data_ready) begin
                    io_data_payload <= shift;
                    io_data_valid   <= 1'b1;
                end else begin
                    io_overrun <= 1'b1;
                end
            end else if (io_data_valid && io_data_ready) begin
                io_data_valid <= 1'b0;
            end
        end
    end

    assign io_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer at 8 clocks per bit: vector table, directed corner sequences, random frames.
module tb_uart_rx_framer;

    localparam int CPB  = 8;
    localparam int SYNC = 2;
    // Cycle (relative to driving the start bit) in which a completed byte becomes visible.
    localparam int DLAT = SYNC + CPB / 2 + 9 * CPB + 1;

    logic       io_clk = 1'b0;
    logic       io_reset_n = 1'b0;
    logic       io_rx = 1'b1;
    logic       io_data_ready = 1'b0;
    logic       io_data_valid;
    logic [7:0] io_data_payload;
    logic       io_frame_err;
    logic       io_overrun;
    logic       io_busy;

    uart_rx_framer #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .io_clk          (io_clk),
        .io_reset_n      (io_reset_n),
        .io_rx           (io_rx),
        .io_data_valid   (io_data_valid),
        .io_data_ready   (io_data_ready),
        .io_data_payload (io_data_payload),
        .io_frame_err    (io_frame_err),
        .io_overrun      (io_overrun),
        .io_busy         (io_busy)
    );

    always #5 io_clk = ~io_clk;

    int cyc = 0;
    always @(posedge io_clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] b;
        logic       good;
    } pend_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_payload;
        logic       exp_fe;
    } vec_t;

    pend_t      pend_q[$];
    logic [7:0] got_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    bit         rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge io_clk);
        #1;
        if (rand_ready) io_data_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic hold(input logic v, input int n);
        io_rx = v;
        repeat (n) step();
    endtask

    task automatic wait_neg(input int k);
        do @(negedge io_clk); while (cyc < k);
    endtask

    // Drives start and data bits; returns with the stop level on the line at cycle c0+9*CPB.
    task automatic frame_begin(input logic [7:0] b, input logic stop, output int c0);
        pend_t p;
        c0     = cyc;
        p.cyc  = c0 + DLAT;
        p.b    = b;
        p.good = stop;
        pend_q.push_back(p);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        io_rx = stop;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        int c0;
        frame_begin(b, stop, c0);
        hold(stop, CPB);
        io_rx = 1'b1;
    endtask

    // Reference model: frame-level delivery schedule plus a one-entry buffer, checked every cycle.
    initial begin
        logic       m_valid = 1'b0;
        logic [7:0] m_payload = 8'h00;
        logic       ready_prev = 1'b0;
        logic       exp_fe;
        logic       exp_ov;
        logic       dg;
        logic [7:0] db;
        pend_t      p;
        forever begin
            @(negedge io_clk);
            exp_fe = 1'b0;
            exp_ov = 1'b0;
            dg     = 1'b0;
            db     = 8'h00;
            if (!io_reset_n) begin
                m_valid   = 1'b0;
                m_payload = 8'h00;
                pend_q.delete();
                check("reset_busy", io_busy, 0);
            end else begin
                if (pend_q.size() > 0 && pend_q[0].cyc == cyc) begin
                    p = pend_q.pop_front();
                    if (p.good) begin
                        dg = 1'b1;
                        db = p.b;
                    end else begin
                        exp_fe = 1'b1;
                    end
                end
                if (dg) begin
                    if (!m_valid || ready_prev) begin
                        m_payload = db;
                        m_valid   = 1'b1;
                    end else begin
                        exp_ov = 1'b1;
                    end
                end else if (m_valid && ready_prev) begin
                    m_valid = 1'b0;
                end
            end
            check("mon_valid", io_data_valid, m_valid);
            check("mon_payload", io_data_payload, m_payload);
            check("mon_frame_err", io_frame_err, exp_fe);
            check("mon_overrun", io_overrun, exp_ov);
            if (io_reset_n && io_data_valid && io_data_ready) got_q.push_back(io_data_payload);
            fe_cnt += int'(io_frame_err);
            ov_cnt += int'(io_overrun);
            ready_prev = io_data_ready;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        n_fail++;
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[5];
        int   c0;
        int   fe0;
        int   ov0;
        logic [7:0] rb;
        logic       rs;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_payload: 8'hA5, exp_fe: 1'b0};
        vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_payload: 8'h00, exp_fe: 1'b0};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_payload: 8'hFF, exp_fe: 1'b0};
        vecs[3] = '{data: 8'h55, stop: 1'b0, exp_valid: 1'b0, exp_payload: 8'hFF, exp_fe: 1'b1};
        vecs[4] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_payload: 8'h81, exp_fe: 1'b0};

        repeat (3) step();
        check("reset_valid", io_data_valid, 0);
        check("reset_payload", io_data_payload, 8'h00);
        check("reset_frame_err", io_frame_err, 0);
        check("reset_overrun", io_overrun, 0);
        check("reset_busy_idle", io_busy, 0);
        io_reset_n = 1'b1;
        hold(1'b1, 4);

        // Vector table with ready held high: each byte is valid for exactly one cycle.
        io_data_ready = 1'b1;
        foreach (vecs[i]) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            frame_begin(vecs[i].data, vecs[i].stop, c0);
            wait_neg(c0 + DLAT);
            check("vec_valid", io_data_valid, vecs[i].exp_valid);
            check("vec_payload", io_data_payload, vecs[i].exp_payload);
            check("vec_frame_err", io_frame_err, vecs[i].exp_fe);
            wait_neg(c0 + DLAT + 1);
            check("vec_valid_drop", io_data_valid, 0);
            check("vec_fe_single", fe_cnt - fe0, 32'(vecs[i].exp_fe));
            check("vec_no_overrun", ov_cnt - ov0, 0);
            step();
            hold(1'b1, 4);
        end

        // Two bytes with ready low: the first is held, the second overruns.
        io_data_ready = 1'b0;
        hold(1'b1, 4);
        got_q.delete();
        ov0 = ov_cnt;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        hold(1'b1, 4);
        check("ovr_count", ov_cnt - ov0, 1);
        check("ovr_held_valid", io_data_valid, 1);
        check("ovr_held_payload", io_data_payload, 8'h3C);
        io_data_ready = 1'b1;
        step();
        io_data_ready = 1'b0;
        hold(1'b1, 3);
        check("ovr_drain_count", got_q.size(), 1);
        if (got_q.size() > 0) check("ovr_drain_byte", got_q[0], 8'h3C);
        check("ovr_drain_valid", io_data_valid, 0);

        // Stop bit low with the line held low afterwards.
        fe0 = fe_cnt;
        frame_begin(8'h55, 1'b0, c0);
        hold(1'b0, CPB + 20);
        io_rx = 1'b1;
        wait_neg(c0 + 101);
        check("ferr_busy_hold", io_busy, 1);
        wait_neg(c0 + 104);
        check("ferr_busy_release", io_busy, 0);
        check("ferr_count", fe_cnt - fe0, 1);
        check("ferr_no_valid", io_data_valid, 0);
        step();
        hold(1'b1, 2);

        // Three-cycle glitch on the line.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        c0 = cyc;
        hold(1'b0, 3);
        io_rx = 1'b1;
        wait_neg(c0 + 4);
        check("glitch_busy", io_busy, 1);
        wait_neg(c0 + 9);
        check("glitch_idle", io_busy, 0);
        step();
        hold(1'b1, 4);
        check("glitch_no_fe", fe_cnt - fe0, 0);
        check("glitch_no_ov", ov_cnt - ov0, 0);
        check("glitch_no_valid", io_data_valid, 0);

        // Reset at data bit 4 of 0xFF, then a clean 0x01.
        io_data_ready = 1'b1;
        got_q.delete();
        hold(1'b0, CPB);
        hold(1'b1, 4 * CPB + 2);
        io_reset_n = 1'b0;
        hold(1'b1, 3);
        io_reset_n = 1'b1;
        hold(1'b1, 5 * CPB);
        send_frame(8'h01, 1'b1);
        hold(1'b1, 4);
        check("rst_mid_count", got_q.size(), 1);
        if (got_q.size() > 0) check("rst_mid_byte", got_q[0], 8'h01);

        // Back-to-back bytes, ready pulsed exactly as the second byte loads.
        io_data_ready = 1'b0;
        got_q.delete();
        ov0 = ov_cnt;
        send_frame(8'h12, 1'b1);
        frame_begin(8'h34, 1'b1, c0);
        repeat (DLAT - 1 - 9 * CPB) step();
        io_data_ready = 1'b1;
        step();
        io_data_ready = 1'b0;
        check("b2b_valid_kept", io_data_valid, 1);
        check("b2b_payload_new", io_data_payload, 8'h34);
        step();
        hold(1'b1, 3);
        io_data_ready = 1'b1;
        step();
        io_data_ready = 1'b0;
        hold(1'b1, 3);
        check("b2b_count", got_q.size(), 2);
        if (got_q.size() > 1) begin
            check("b2b_first", got_q[0], 8'h12);
            check("b2b_second", got_q[1], 8'h34);
        end
        check("b2b_no_overrun", ov_cnt - ov0, 0);

        // Random bytes, stop errors and ready activity, checked by the per-cycle model.
        rand_ready = 1'b1;
        for (int n = 0; n < 14; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            send_frame(rb, rs);
            hold(1'b1, rs ? $urandom_range(0, 5) : $urandom_range(1, 5));
        end
        rand_ready = 1'b0;
        io_data_ready = 1'b1;
        hold(1'b1, 6);
        check("rand_drained", io_data_valid, 0);
        check("rand_idle", io_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
